// File: rtl/priority_arb_enc_v_if.sv
// Request/grant bundle between a bank of requesters and the priority encoder.
// slave = the encoder side, master = the requester/consumer side.
interface priority_arb_enc_v_if #(
  parameter int N = 8,
  parameter int W = ($clog2(N) < 1) ? 1 : $clog2(N)
);
  logic [N-1:0] i_req;
  logic         i_ready;
  logic [W-1:0] o_code;
  logic [N-1:0] o_grant;
  logic         o_valid;

  modport slave  (input  i_req, i_ready, output o_code, o_grant, o_valid);
  modport master (output i_req, i_ready, input  o_code, o_grant, o_valid);
endinterface

// File: rtl/priority_arb_enc_v.sv
// Registered N-to-log2(N) priority encoder with held grant and valid/ready
// accept; fixed priority (line 0 highest) or round-robin selection.
module priority_arb_enc_v #(
  parameter int N       = 8,
  parameter int W       = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter bit RR_MODE = 1'b0
) (
  input logic                  i_clk,
  input logic                  i_rst,
  priority_arb_enc_v_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   code_q, code_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic           accept;
  logic [W-1:0]   next_ptr;
  logic [W-1:0]   search_base;
  logic [2*N-1:0] req2, rot;
  logic           win_found;
  logic [W:0]     win_off, win_sum;
  logic [W-1:0]   win_idx;
  logic [N-1:0]   win_oh;

  assign accept   = (state_q == GRANT) && bus.i_ready;
  // Wrap at N, not 2^W, so unused codes are never produced for odd N.
  assign next_ptr = (code_q == W'(N-1)) ? '0 : code_q + W'(1);

  // On an accept edge the reload already sees the advanced pointer.
  always_comb begin
    search_base = '0;
    if (RR_MODE)
      search_base = accept ? next_ptr : ptr_q;
  end

  // Rotate requests so search_base lands at bit 0, then find the lowest set bit.
  always_comb begin
    req2      = {bus.i_req, bus.i_req};
    rot       = req2 >> search_base;
    win_found = 1'b0;
    win_off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && rot[k]) begin
        win_found = 1'b1;
        win_off   = (W+1)'(k);
      end
    end
    win_sum = {1'b0, search_base} + win_off;
    win_idx = (win_sum >= (W+1)'(N)) ? W'(win_sum - (W+1)'(N)) : W'(win_sum);
    win_oh  = N'(1) << win_idx;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          code_d  = win_idx;
          grant_d = win_oh;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.i_ready) begin
          if (RR_MODE)
            ptr_d = next_ptr;
          if (win_found) begin
            code_d  = win_idx;
            grant_d = win_oh;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_code  = code_q;
  assign bus.o_grant = grant_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_priority_arb_enc_v.sv
// Three encoder instances (N=8 fixed, N=4 RR, N=5 RR) driven by directed and
// random steps and compared against a per-line search model.
module tb_priority_arb_enc_v;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  priority_arb_enc_v_if #(.N(8)) if8 ();
  priority_arb_enc_v_if #(.N(4)) if4 ();
  priority_arb_enc_v_if #(.N(5)) if5 ();

  priority_arb_enc_v #(.N(8), .RR_MODE(1'b0)) d8 (.i_clk(clk), .i_rst(rst), .bus(if8));
  priority_arb_enc_v #(.N(4), .RR_MODE(1'b1)) d4 (.i_clk(clk), .i_rst(rst), .bus(if4));
  priority_arb_enc_v #(.N(5), .RR_MODE(1'b1)) d5 (.i_clk(clk), .i_rst(rst), .bus(if5));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: grant present, granted line, rotation start.
  int nn [3] = '{8, 4, 5};
  bit rr [3] = '{1'b0, 1'b1, 1'b1};
  bit mv [3] = '{1'b0, 1'b0, 1'b0};
  int mc [3] = '{0, 0, 0};
  int mp [3] = '{0, 0, 0};

  function automatic int pick(int req, int n, int start);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (start + k) % n;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void upd(int i, int req, bit rdy, bit r);
    if (r) begin
      mv[i] = 1'b0; mc[i] = 0; mp[i] = 0;
    end else if (!mv[i]) begin
      if (req != 0) begin
        mc[i] = pick(req, nn[i], rr[i] ? mp[i] : 0);
        mv[i] = 1'b1;
      end
    end else if (rdy) begin
      if (rr[i]) mp[i] = (mc[i] + 1) % nn[i];
      if (req != 0) mc[i] = pick(req, nn[i], rr[i] ? mp[i] : 0);
      else          mv[i] = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_grant(int i);
    return mv[i] ? (32'd1 << mc[i]) : 32'd0;
  endfunction

  task automatic step(input logic [7:0] r8, input logic [3:0] r4, input logic [4:0] r5,
                      input logic y8, input logic y4, input logic y5, input logic r);
    if8.i_req = r8; if8.i_ready = y8;
    if4.i_req = r4; if4.i_ready = y4;
    if5.i_req = r5; if5.i_ready = y5;
    rst = r;
    @(posedge clk);
    upd(0, int'(r8), y8, r);
    upd(1, int'(r4), y4, r);
    upd(2, int'(r5), y5, r);
    #1;
    chk("d8.valid", 32'(if8.o_valid), 32'(mv[0]));
    chk("d8.code",  32'(if8.o_code),  mc[0]);
    chk("d8.grant", 32'(if8.o_grant), exp_grant(0));
    chk("d4.valid", 32'(if4.o_valid), 32'(mv[1]));
    chk("d4.code",  32'(if4.o_code),  mc[1]);
    chk("d4.grant", 32'(if4.o_grant), exp_grant(1));
    chk("d5.valid", 32'(if5.o_valid), 32'(mv[2]));
    chk("d5.code",  32'(if5.o_code),  mc[2]);
    chk("d5.grant", 32'(if5.o_grant), exp_grant(2));
  endtask

  initial begin
    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    if8.i_req = '0; if8.i_ready = 1'b0;
    if4.i_req = '0; if4.i_ready = 1'b0;
    if5.i_req = '0; if5.i_ready = 1'b0;

    // Reset
    step(8'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.valid", 32'(if8.o_valid), 0);
    chk("rst.code",  32'(if8.o_code),  0);
    chk("rst.grant", 32'(if8.o_grant), 0);

    // Fixed priority, backpressure hold, RR fairness and N=5 wrap in parallel
    step(8'hA4, 4'hF, 5'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fix.code",  32'(if8.o_code),  2);
    chk("fix.grant", 32'(if8.o_grant), 32'h04);
    chk("fix.valid", 32'(if8.o_valid), 1);
    chk("rr4.seq0",  32'(if4.o_code),  rr_seq[0]);
    chk("n5.code4",  32'(if5.o_code),  4);
    step(8'h01, 4'hF, 5'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("hold.code", 32'(if8.o_code),  2);
    chk("rr4.seq1",  32'(if4.o_code),  rr_seq[1]);
    chk("n5.wrap0",  32'(if5.o_code),  0);
    step(8'h01, 4'hF, 5'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("hold.code", 32'(if8.o_code),  2);
    chk("rr4.seq2",  32'(if4.o_code),  rr_seq[2]);
    chk("n5.next4",  32'(if5.o_code),  4);
    step(8'h01, 4'hF, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("hold.code",  32'(if8.o_code),  2);
    chk("hold.valid", 32'(if8.o_valid), 1);
    chk("rr4.seq3",   32'(if4.o_code),  rr_seq[3]);
    chk("n5.idle",    32'(if5.o_valid), 0);
    step(8'h01, 4'hF, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold.next", 32'(if8.o_code), 0);
    chk("rr4.seq4",  32'(if4.o_code), rr_seq[4]);
    step(8'h80, 4'hF, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rr4.seq5",  32'(if4.o_code),  rr_seq[5]);
    chk("rr4.valid", 32'(if4.o_valid), 1);

    // Reset mid-operation with ready asserted, then RR restart from line 0
    step(8'hFF, 4'hF, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst.valid", 32'(if8.o_valid), 0);
    chk("midrst.grant", 32'(if8.o_grant), 0);
    chk("midrst.code",  32'(if4.o_code),  0);
    step(8'h00, 4'hF, 5'h1F, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("postrst.rr4", 32'(if4.o_code), 0);
    chk("postrst.rr5", 32'(if5.o_code), 0);

    // Idle, then a single-cycle pulse held until accepted
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle.valid", 32'(if8.o_valid), 0);
    end
    step(8'h80, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pulse.code", 32'(if8.o_code), 7);
    for (int i = 0; i < 2; i++) begin
      step(8'h00, 4'h0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("pulse.held", 32'(if8.o_valid), 1);
    end
    step(8'h00, 4'h0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pulse.done", 32'(if8.o_valid), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), 4'($urandom), 5'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
